// File: rtl/router_pkg.sv
// Shared constants and header field helpers for the router datapath.
//   CHK_XOR / CHK_SUM         : check-function selectors for CHK_MODE
//   ERR_CHK_BIT / ERR_LEN_BIT : bit positions inside err_code
//   hdr_len() / hdr_addr()    : extract header fields from a zero-extended header word
package router_pkg;

    localparam int CHK_XOR     = 0;
    localparam int CHK_SUM     = 1;

    localparam int ERR_CHK_BIT = 0;
    localparam int ERR_LEN_BIT = 1;

    // Header is {len, addr}; len occupies bits [data_width-1:addr_width].
    function automatic logic [31:0] hdr_len(input logic [31:0] hdr,
                                            input int          data_width,
                                            input int          addr_width);
        logic [31:0] mask;
        mask = (32'd1 << (data_width - addr_width)) - 32'd1;
        return (hdr >> addr_width) & mask;
    endfunction

    function automatic logic [31:0] hdr_addr(input logic [31:0] hdr,
                                             input int          addr_width);
        logic [31:0] mask;
        mask = (32'd1 << addr_width) - 32'd1;
        return hdr & mask;
    endfunction

endpackage

// File: rtl/router_chk_acc.sv
// Packet check accumulator: XOR parity or modulo-2^DATA_WIDTH sum.
//   clock, reset : clock and asynchronous active-high reset
//   clear        : zero the accumulator (takes priority over en)
//   en           : fold din into the accumulator
//   din          : byte to accumulate
//   acc          : running check value
module router_chk_acc
    import router_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int CHK_MODE   = CHK_XOR
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  en,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] acc
);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            acc <= '0;
        end else if (clear) begin
            acc <= '0;
        end else if (en) begin
            // Sum carries fall off the top of the register.
            acc <= (CHK_MODE == CHK_SUM) ? (acc + din) : (acc ^ din);
        end
    end

endmodule

// File: rtl/router_reg_ext.sv
// Packet data register between the router input port and the per-port FIFOs.
// Latches the header, forwards payload bytes, parks one byte while the FIFO is
// full, and checks each packet (check function plus payload length).
//   clock, reset                      : clock, asynchronous active-high reset
//   pkt_valid, fifo_full, data_in     : input stream and FIFO back-pressure
//   detect_add, lfd_state, ld_state,
//   laf_state, full_state, rst_int_reg: router FSM state strobes
//   dout                              : byte written to the FIFO
//   parity_done, low_pkt_valid        : check byte captured / pkt_valid fell
//   err, err_code, addr_err           : check/length errors, bad destination
module router_reg_ext
    import router_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 2,
    parameter int NUM_PORTS  = 3,
    parameter int CHK_MODE   = CHK_XOR,
    parameter int LEN_CHECK  = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  pkt_valid,
    input  logic                  fifo_full,
    input  logic                  detect_add,
    input  logic                  lfd_state,
    input  logic                  ld_state,
    input  logic                  laf_state,
    input  logic                  full_state,
    input  logic                  rst_int_reg,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  parity_done,
    output logic                  low_pkt_valid,
    output logic                  err,
    output logic [1:0]            err_code,
    output logic                  addr_err
);

    localparam int LEN_W = DATA_WIDTH - ADDR_WIDTH;
    localparam int CNT_W = LEN_W + 1;

    logic [DATA_WIDTH-1:0] hdr_reg;
    logic [DATA_WIDTH-1:0] hold_reg;
    logic [DATA_WIDTH-1:0] rx_chk;
    logic [DATA_WIDTH-1:0] chk_acc;
    logic [CNT_W-1:0]      pay_cnt;
    logic                  addr_pend;
    logic                  eval_pend;
    logic [31:0]           hdr_ext;
    logic [31:0]           len_ext;
    logic [31:0]           addr_ext;
    logic                  capture;
    logic                  acc_en;
    logic [DATA_WIDTH-1:0] acc_din;

    assign hdr_ext  = 32'(hdr_reg);
    assign len_ext  = hdr_len(hdr_ext, DATA_WIDTH, ADDR_WIDTH);
    assign addr_ext = hdr_addr(hdr_ext, ADDR_WIDTH);

    assign capture  = detect_add && pkt_valid;
    // A new header wins over any load activity in the same cycle.
    assign acc_en   = !detect_add &&
                      (lfd_state || (ld_state && pkt_valid && !full_state && !fifo_full));
    assign acc_din  = lfd_state ? hdr_reg : data_in;

    router_chk_acc #(
        .DATA_WIDTH (DATA_WIDTH),
        .CHK_MODE   (CHK_MODE)
    ) u_chk_acc (
        .clock (clock),
        .reset (reset),
        .clear (capture),
        .en    (acc_en),
        .din   (acc_din),
        .acc   (chk_acc)
    );

    assign err = |err_code;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hdr_reg     <= '0;
            hold_reg    <= '0;
            rx_chk      <= '0;
            dout        <= '0;
            pay_cnt     <= '0;
            parity_done <= 1'b0;
            err_code    <= 2'b00;
            addr_err    <= 1'b0;
            addr_pend   <= 1'b0;
            eval_pend   <= 1'b0;
        end else begin
            addr_pend <= 1'b0;
            eval_pend <= 1'b0;

            // Evaluations one cycle behind their trigger; a header capture
            // below overrides them because its clears are assigned later.
            if (addr_pend) begin
                addr_err <= (addr_ext >= 32'(NUM_PORTS));
            end
            if (eval_pend) begin
                err_code[ERR_CHK_BIT] <= (chk_acc != rx_chk);
                err_code[ERR_LEN_BIT] <= (LEN_CHECK != 0) && (32'(pay_cnt) != len_ext);
            end

            if (detect_add) begin
                if (pkt_valid) begin
                    hdr_reg     <= data_in;
                    pay_cnt     <= '0;
                    parity_done <= 1'b0;
                    err_code    <= 2'b00;
                    addr_err    <= 1'b0;
                    addr_pend   <= 1'b1;
                end
            end else begin
                if (lfd_state) begin
                    dout <= hdr_reg;
                end

                if (ld_state) begin
                    if (fifo_full) begin
                        hold_reg <= data_in;
                    end else begin
                        dout <= data_in;
                    end

                    if (pkt_valid && !full_state && !fifo_full && (pay_cnt != '1)) begin
                        pay_cnt <= pay_cnt + 1'b1;
                    end

                    // Check byte: completes now, or after LOAD_AFTER_FULL
                    // replays it when the FIFO was full.
                    if (!pkt_valid && !parity_done) begin
                        rx_chk <= data_in;
                        if (!fifo_full) begin
                            parity_done <= 1'b1;
                            eval_pend   <= 1'b1;
                        end
                    end
                end

                if (laf_state) begin
                    dout <= hold_reg;
                    if (low_pkt_valid && !parity_done) begin
                        parity_done <= 1'b1;
                        eval_pend   <= 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            low_pkt_valid <= 1'b0;
        end else if (rst_int_reg) begin
            low_pkt_valid <= 1'b0;
        end else if (ld_state && !pkt_valid && !detect_add) begin
            low_pkt_valid <= 1'b1;
        end
    end

endmodule

// File: tb/tb_router_reg_ext.sv
module tb_router_reg_ext;

    logic       clock = 1'b0;
    logic       reset;
    logic       pkt_valid, fifo_full, detect_add, lfd_state, ld_state;
    logic       laf_state, full_state, rst_int_reg;
    logic [7:0] data_in;

    // a_: XOR + length check, n_: XOR without length check, s_: sum check
    logic [7:0] a_dout, n_dout, s_dout;
    logic       a_pd, n_pd, s_pd;
    logic       a_lpv, n_lpv, s_lpv;
    logic       a_err, n_err, s_err;
    logic [1:0] a_ec, n_ec, s_ec;
    logic       a_ae, n_ae, s_ae;

    int         vectors     = 0;
    int         miscompares = 0;

    logic [7:0] pay [16];
    logic [7:0] dq [$];
    logic       pd_at_chk, err_at_chk, lpv_at_chk;
    logic [7:0] dout_full, dout_laf;

    always #5 clock = ~clock;

    router_reg_ext #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .NUM_PORTS(3), .CHK_MODE(0), .LEN_CHECK(1)) dut_a (
        .clock(clock), .reset(reset), .pkt_valid(pkt_valid), .fifo_full(fifo_full),
        .detect_add(detect_add), .lfd_state(lfd_state), .ld_state(ld_state),
        .laf_state(laf_state), .full_state(full_state), .rst_int_reg(rst_int_reg),
        .data_in(data_in), .dout(a_dout), .parity_done(a_pd), .low_pkt_valid(a_lpv),
        .err(a_err), .err_code(a_ec), .addr_err(a_ae));

    router_reg_ext #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .NUM_PORTS(3), .CHK_MODE(0), .LEN_CHECK(0)) dut_n (
        .clock(clock), .reset(reset), .pkt_valid(pkt_valid), .fifo_full(fifo_full),
        .detect_add(detect_add), .lfd_state(lfd_state), .ld_state(ld_state),
        .laf_state(laf_state), .full_state(full_state), .rst_int_reg(rst_int_reg),
        .data_in(data_in), .dout(n_dout), .parity_done(n_pd), .low_pkt_valid(n_lpv),
        .err(n_err), .err_code(n_ec), .addr_err(n_ae));

    router_reg_ext #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .NUM_PORTS(3), .CHK_MODE(1), .LEN_CHECK(1)) dut_s (
        .clock(clock), .reset(reset), .pkt_valid(pkt_valid), .fifo_full(fifo_full),
        .detect_add(detect_add), .lfd_state(lfd_state), .ld_state(ld_state),
        .laf_state(laf_state), .full_state(full_state), .rst_int_reg(rst_int_reg),
        .data_in(data_in), .dout(s_dout), .parity_done(s_pd), .low_pkt_valid(s_lpv),
        .err(s_err), .err_code(s_ec), .addr_err(s_ae));

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        pkt_valid   = 1'b0; fifo_full  = 1'b0; detect_add  = 1'b0; lfd_state = 1'b0;
        ld_state    = 1'b0; laf_state  = 1'b0; full_state  = 1'b0; rst_int_reg = 1'b0;
        data_in     = 8'h00;
    endtask

    // Drives one packet as the router FSM would. dout is recorded after the
    // LOAD_FIRST_DATA edge and after every payload byte reaches the FIFO.
    task automatic send_pkt(input logic [7:0] hdr, input int n, input logic [7:0] chk,
                            input int full_idx, input bit b2b);
        dq.delete();
        idle_inputs();
        detect_add = 1'b1; pkt_valid = 1'b1; data_in = hdr;
        step();
        detect_add = 1'b0; lfd_state = 1'b1; data_in = (n > 0) ? pay[0] : chk;
        step();
        dq.push_back(a_dout);
        lfd_state = 1'b0; ld_state = 1'b1;
        for (int i = 0; i < n; i++) begin
            data_in = pay[i]; pkt_valid = 1'b1;
            if (i == full_idx) begin
                fifo_full = 1'b1;
                step();
                dout_full = a_dout;
                ld_state = 1'b0; full_state = 1'b1;
                step();
                full_state = 1'b0; fifo_full = 1'b0; laf_state = 1'b1;
                step();
                dout_laf = a_dout;
                dq.push_back(a_dout);
                laf_state = 1'b0; ld_state = 1'b1;
            end else begin
                step();
                dq.push_back(a_dout);
            end
        end
        pkt_valid = 1'b0; data_in = chk;
        step();
        pd_at_chk = a_pd; err_at_chk = a_err; lpv_at_chk = a_lpv;
        ld_state = 1'b0;
        if (!b2b) begin
            rst_int_reg = 1'b1;
            step();
            rst_int_reg = 1'b0;
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        step(); step();
        reset = 1'b0;
        step();
        vectors++; if (a_dout !== 8'h00) begin miscompares++; $display("FAIL reset_dout: got %h expected 00", a_dout); end
        vectors++; if (a_pd !== 1'b0) begin miscompares++; $display("FAIL reset_parity_done: got %b expected 0", a_pd); end
        vectors++; if (a_lpv !== 1'b0) begin miscompares++; $display("FAIL reset_low_pkt_valid: got %b expected 0", a_lpv); end
        vectors++; if (a_err !== 1'b0) begin miscompares++; $display("FAIL reset_err: got %b expected 0", a_err); end
        vectors++; if (a_ec !== 2'b00) begin miscompares++; $display("FAIL reset_err_code: got %b expected 00", a_ec); end
        vectors++; if (a_ae !== 1'b0) begin miscompares++; $display("FAIL reset_addr_err: got %b expected 0", a_ae); end
    endtask

    // Header 22 (len 8, addr 2), payload 01..08, XOR of all = 2A.
    task automatic test_good_packet();
        logic [7:0] exp;
        for (int i = 0; i < 8; i++) pay[i] = 8'(i + 1);
        send_pkt(8'h22, 8, 8'h2A, -1, 1'b0);
        vectors++; if (dq.size() !== 9) begin miscompares++; $display("FAIL good_dout_count: got %0d expected 9", dq.size()); end
        for (int i = 0; i < 9; i++) begin
            exp = (i == 0) ? 8'h22 : pay[i-1];
            vectors++; if (dq[i] !== exp) begin miscompares++; $display("FAIL good_dout[%0d]: got %h expected %h", i, dq[i], exp); end
        end
        vectors++; if (pd_at_chk !== 1'b1) begin miscompares++; $display("FAIL good_parity_done: got %b expected 1", pd_at_chk); end
        vectors++; if (lpv_at_chk !== 1'b1) begin miscompares++; $display("FAIL good_low_pkt_valid_set: got %b expected 1", lpv_at_chk); end
        vectors++; if (a_lpv !== 1'b0) begin miscompares++; $display("FAIL good_low_pkt_valid_clr: got %b expected 0", a_lpv); end
        vectors++; if (a_err !== 1'b0) begin miscompares++; $display("FAIL good_err: got %b expected 0", a_err); end
        vectors++; if (a_ec !== 2'b00) begin miscompares++; $display("FAIL good_err_code: got %b expected 00", a_ec); end
        vectors++; if (a_ae !== 1'b0) begin miscompares++; $display("FAIL good_addr_err: got %b expected 0", a_ae); end
        vectors++; if (a_pd !== 1'b1) begin miscompares++; $display("FAIL good_parity_done_sticky: got %b expected 1", a_pd); end
    endtask

    task automatic test_bad_parity();
        for (int i = 0; i < 8; i++) pay[i] = 8'(i + 1);
        send_pkt(8'h22, 8, 8'hD5, -1, 1'b0);
        vectors++; if (err_at_chk !== 1'b0) begin miscompares++; $display("FAIL badpar_err_early: got %b expected 0", err_at_chk); end
        vectors++; if (a_ec !== 2'b01) begin miscompares++; $display("FAIL badpar_err_code: got %b expected 01", a_ec); end
        vectors++; if (a_err !== 1'b1) begin miscompares++; $display("FAIL badpar_err: got %b expected 1", a_err); end
        idle_inputs();
        detect_add = 1'b1; pkt_valid = 1'b1; data_in = 8'h22;
        step();
        idle_inputs();
        vectors++; if (a_err !== 1'b0) begin miscompares++; $display("FAIL badpar_err_cleared: got %b expected 0", a_err); end
        vectors++; if (a_ec !== 2'b00) begin miscompares++; $display("FAIL badpar_code_cleared: got %b expected 00", a_ec); end
        vectors++; if (a_pd !== 1'b0) begin miscompares++; $display("FAIL badpar_pd_cleared: got %b expected 0", a_pd); end
    endtask

    // Seven bytes 01..07 XOR to 00, so the check byte is the header 22.
    task automatic test_short_len();
        for (int i = 0; i < 7; i++) pay[i] = 8'(i + 1);
        send_pkt(8'h22, 7, 8'h22, -1, 1'b0);
        vectors++; if (a_ec !== 2'b10) begin miscompares++; $display("FAIL short_err_code: got %b expected 10", a_ec); end
        vectors++; if (a_err !== 1'b1) begin miscompares++; $display("FAIL short_err: got %b expected 1", a_err); end
        vectors++; if (n_err !== 1'b0) begin miscompares++; $display("FAIL short_nolen_err: got %b expected 0", n_err); end
        vectors++; if (n_ec !== 2'b00) begin miscompares++; $display("FAIL short_nolen_err_code: got %b expected 00", n_ec); end
    endtask

    // A5 is parked during the full cycle and is not accumulated; the check
    // byte is the XOR of header and the other seven bytes (F2).
    task automatic test_fifo_full();
        logic [7:0] exp;
        pay[0] = 8'h10; pay[1] = 8'h20; pay[2] = 8'h30; pay[3] = 8'h40;
        pay[4] = 8'hA5; pay[5] = 8'h60; pay[6] = 8'h70; pay[7] = 8'h80;
        send_pkt(8'h22, 8, 8'hF2, 4, 1'b0);
        vectors++; if (dout_full !== 8'h40) begin miscompares++; $display("FAIL full_dout_hold: got %h expected 40", dout_full); end
        vectors++; if (dout_laf !== 8'hA5) begin miscompares++; $display("FAIL full_dout_laf: got %h expected a5", dout_laf); end
        vectors++; if (dq.size() !== 9) begin miscompares++; $display("FAIL full_dout_count: got %0d expected 9", dq.size()); end
        for (int i = 0; i < 9; i++) begin
            exp = (i == 0) ? 8'h22 : pay[i-1];
            vectors++; if (dq[i] !== exp) begin miscompares++; $display("FAIL full_dout[%0d]: got %h expected %h", i, dq[i], exp); end
        end
        vectors++; if (a_ec[0] !== 1'b0) begin miscompares++; $display("FAIL full_chk_unchanged: got %b expected 0", a_ec[0]); end
        vectors++; if (pd_at_chk !== 1'b1) begin miscompares++; $display("FAIL full_parity_done: got %b expected 1", pd_at_chk); end
    endtask

    // Header 05 (len 1, addr 1), payload 33, check 36 arrives while full.
    task automatic test_full_on_check();
        idle_inputs();
        detect_add = 1'b1; pkt_valid = 1'b1; data_in = 8'h05;
        step();
        detect_add = 1'b0; lfd_state = 1'b1; data_in = 8'h33;
        step();
        lfd_state = 1'b0; ld_state = 1'b1;
        step();
        pkt_valid = 1'b0; fifo_full = 1'b1; data_in = 8'h36;
        step();
        vectors++; if (a_pd !== 1'b0) begin miscompares++; $display("FAIL fchk_pd_deferred: got %b expected 0", a_pd); end
        vectors++; if (a_lpv !== 1'b1) begin miscompares++; $display("FAIL fchk_lpv: got %b expected 1", a_lpv); end
        ld_state = 1'b0; full_state = 1'b1;
        step();
        full_state = 1'b0; fifo_full = 1'b0; laf_state = 1'b1;
        step();
        vectors++; if (a_pd !== 1'b1) begin miscompares++; $display("FAIL fchk_pd_laf: got %b expected 1", a_pd); end
        vectors++; if (a_dout !== 8'h36) begin miscompares++; $display("FAIL fchk_dout: got %h expected 36", a_dout); end
        laf_state = 1'b0; rst_int_reg = 1'b1;
        step();
        idle_inputs();
        vectors++; if (a_ec !== 2'b00) begin miscompares++; $display("FAIL fchk_err_code: got %b expected 00", a_ec); end
    endtask

    // Sum mode: 0A + F0 + 20 = 11A -> 1A.
    task automatic test_sum_mode();
        pay[0] = 8'hF0; pay[1] = 8'h20;
        send_pkt(8'h0A, 2, 8'h1A, -1, 1'b0);
        vectors++; if (s_pd !== 1'b1) begin miscompares++; $display("FAIL sum_parity_done: got %b expected 1", s_pd); end
        vectors++; if (s_err !== 1'b0) begin miscompares++; $display("FAIL sum_good_err: got %b expected 0", s_err); end
        send_pkt(8'h0A, 2, 8'h1B, -1, 1'b0);
        vectors++; if (s_ec !== 2'b01) begin miscompares++; $display("FAIL sum_bad_err_code: got %b expected 01", s_ec); end
        vectors++; if (s_err !== 1'b1) begin miscompares++; $display("FAIL sum_bad_err: got %b expected 1", s_err); end
    endtask

    // Header 01: len 0, addr 1, check byte equals header.
    task automatic test_zero_len();
        send_pkt(8'h01, 0, 8'h01, -1, 1'b0);
        vectors++; if (dq[0] !== 8'h01) begin miscompares++; $display("FAIL zlen_dout_hdr: got %h expected 01", dq[0]); end
        vectors++; if (pd_at_chk !== 1'b1) begin miscompares++; $display("FAIL zlen_parity_done: got %b expected 1", pd_at_chk); end
        vectors++; if (a_ec !== 2'b00) begin miscompares++; $display("FAIL zlen_err_code: got %b expected 00", a_ec); end
    endtask

    // Second header lands in the cycle right after the first check byte.
    task automatic test_back_to_back();
        logic [7:0] exp;
        pay[0] = 8'h11; pay[1] = 8'h22;
        send_pkt(8'h09, 2, 8'h3A, -1, 1'b1);
        vectors++; if (pd_at_chk !== 1'b1) begin miscompares++; $display("FAIL b2b_first_pd: got %b expected 1", pd_at_chk); end
        pay[0] = 8'hC3;
        send_pkt(8'h04, 1, 8'hC7, -1, 1'b0);
        for (int i = 0; i < 2; i++) begin
            exp = (i == 0) ? 8'h04 : pay[0];
            vectors++; if (dq[i] !== exp) begin miscompares++; $display("FAIL b2b_dout[%0d]: got %h expected %h", i, dq[i], exp); end
        end
        vectors++; if (pd_at_chk !== 1'b1) begin miscompares++; $display("FAIL b2b_second_pd: got %b expected 1", pd_at_chk); end
        vectors++; if (a_ec !== 2'b00) begin miscompares++; $display("FAIL b2b_err_code: got %b expected 00", a_ec); end
        vectors++; if (a_ae !== 1'b0) begin miscompares++; $display("FAIL b2b_addr_err: got %b expected 0", a_ae); end
    endtask

    task automatic test_addr_err_and_reset();
        idle_inputs();
        detect_add = 1'b1; pkt_valid = 1'b1; data_in = 8'h13;
        step();
        vectors++; if (a_ae !== 1'b0) begin miscompares++; $display("FAIL addr_err_early: got %b expected 0", a_ae); end
        detect_add = 1'b0; lfd_state = 1'b1; data_in = 8'h55;
        step();
        vectors++; if (a_ae !== 1'b1) begin miscompares++; $display("FAIL addr_err_set: got %b expected 1", a_ae); end
        lfd_state = 1'b0; ld_state = 1'b1; data_in = 8'h55;
        step();
        data_in = 8'h66;
        step();
        reset = 1'b1;
        #2;
        vectors++; if (a_dout !== 8'h00) begin miscompares++; $display("FAIL midrst_dout: got %h expected 00", a_dout); end
        vectors++; if (a_ae !== 1'b0) begin miscompares++; $display("FAIL midrst_addr_err: got %b expected 0", a_ae); end
        vectors++; if (a_pd !== 1'b0) begin miscompares++; $display("FAIL midrst_parity_done: got %b expected 0", a_pd); end
        idle_inputs();
        step();
        reset = 1'b0;
        step();
        for (int i = 0; i < 8; i++) pay[i] = 8'(i + 1);
        send_pkt(8'h22, 8, 8'h2A, -1, 1'b0);
        vectors++; if (a_err !== 1'b0) begin miscompares++; $display("FAIL postrst_err: got %b expected 0", a_err); end
        vectors++; if (a_ae !== 1'b0) begin miscompares++; $display("FAIL postrst_addr_err: got %b expected 0", a_ae); end
        vectors++; if (a_pd !== 1'b1) begin miscompares++; $display("FAIL postrst_parity_done: got %b expected 1", a_pd); end
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        test_reset();
        test_good_packet();
        test_bad_parity();
        test_short_len();
        test_fifo_full();
        test_full_on_check();
        test_sum_mode();
        test_zero_len();
        test_back_to_back();
        test_addr_err_and_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
